// File: rtl/tpg_pkg.sv
// Shared types and constants for the LFSR test-pattern generator / fault run controller.
//   tpg_state_e : run-controller FSM states
//   LfsrPoly    : feedback taps for x^32 + x^22 + x^2 + x + 1 (Galois form, left shift)
//   DefSeed     : default LFSR seed
//   nchunk()    : number of 32-bit LFSR words needed to fill a vector of the given width
package tpg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StApply,
    StCheck,
    StDone
  } tpg_state_e;

  localparam logic [31:0] LfsrPoly = 32'h0040_0007;
  localparam logic [31:0] DefSeed  = 32'h0000_0001;

  function automatic int unsigned nchunk(input int unsigned vec_w);
    return (vec_w + 32'd31) / 32'd32;
  endfunction

endpackage

// File: rtl/tpg_lfsr32.sv
// 32-bit Galois LFSR used as the pattern source.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset, loads seed
//   load : reload seed (has priority over step)
//   step : advance one state: q = (q << 1) ^ (q[31] ? LfsrPoly : 0)
//   seed : value loaded on rst/load (caller guarantees non-zero)
//   q    : current LFSR word
module tpg_lfsr32
  import tpg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] q
);

  logic [31:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      lfsr_q <= seed;
    end else if (step) begin
      lfsr_q <= (lfsr_q << 1) ^ (lfsr_q[31] ? LfsrPoly : 32'h0);
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/tpg_fault_sequencer.sv
// LFSR test-pattern generator and per-fault run controller for serial fault simulation.
// Each run replays the same pattern sequence (LFSR reloaded on start) and ends on the first
// mismatch or after num_pat patterns; running fault/detection counts are kept for coverage.
// Optional feature: define TPG_ABORT_EN to add the 'abort' input (drop to idle, no done pulse,
// no counter change).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin a run (accepted only in idle); num_pat sampled then
//   clr_stats   : synchronous clear of fault_cnt/det_cnt
//   mismatch    : good/faulty comparator result, sampled in the check cycle
//   vec_out     : CUT input vector, vec_valid while applied and stable
//   busy, done  : not idle / one-cycle end-of-run pulse
//   detected, det_index : last run result and detecting pattern index
//   fault_cnt, det_cnt  : saturating run and detection counters
module tpg_fault_sequencer
  import tpg_pkg::*;
#(
  parameter int unsigned VEC_W  = 178,
  parameter int unsigned SETTLE = 2,
  parameter logic [31:0] SEED   = DefSeed
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      num_pat,
  input  logic             clr_stats,
  input  logic             mismatch,
`ifdef TPG_ABORT_EN
  input  logic             abort,
`endif
  output logic [VEC_W-1:0] vec_out,
  output logic             vec_valid,
  output logic             busy,
  output logic             done,
  output logic             detected,
  output logic [15:0]      det_index,
  output logic [15:0]      fault_cnt,
  output logic [15:0]      det_cnt
);

  localparam int unsigned NChunk  = nchunk(VEC_W);
  // An all-zero LFSR would lock up.
  localparam logic [31:0] SeedEff = (SEED == 32'h0) ? 32'h1 : SEED;

  tpg_state_e       state_q, state_d;
  logic [15:0]      sub_cnt_q, sub_cnt_d;
  logic [15:0]      pat_idx_q, pat_idx_d;
  logic [15:0]      num_pat_q, num_pat_d;
  logic             detected_q, detected_d;
  logic [15:0]      det_index_q, det_index_d;
  logic [15:0]      fault_cnt_q, fault_cnt_d;
  logic [15:0]      det_cnt_q, det_cnt_d;
  logic [VEC_W-1:0] sr_q, sr_d;
  logic             lfsr_load, lfsr_step;
  logic [31:0]      lfsr_word;
  logic             abort_req;

`ifdef TPG_ABORT_EN
  assign abort_req = abort && (state_q != StIdle);
`else
  assign abort_req = 1'b0;
`endif

  tpg_lfsr32 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .step (lfsr_step),
    .seed (SeedEff),
    .q    (lfsr_word)
  );

  always_comb begin
    state_d     = state_q;
    sub_cnt_d   = sub_cnt_q;
    pat_idx_d   = pat_idx_q;
    num_pat_d   = num_pat_q;
    detected_d  = detected_q;
    det_index_d = det_index_q;
    fault_cnt_d = fault_cnt_q;
    det_cnt_d   = det_cnt_q;
    sr_d        = sr_q;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;

    if (abort_req) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            lfsr_load   = 1'b1;
            pat_idx_d   = 16'd0;
            sub_cnt_d   = 16'd0;
            detected_d  = 1'b0;
            det_index_d = 16'd0;
            num_pat_d   = num_pat;
            state_d     = (num_pat == 16'd0) ? StDone : StFill;
          end
        end
        StFill: begin
          // Only the low VEC_W bits of the conceptual 32*NChunk register are ever visible.
          sr_d      = VEC_W'({sr_q, lfsr_word});
          lfsr_step = 1'b1;
          if (sub_cnt_q == 16'(NChunk - 1)) begin
            sub_cnt_d = 16'd0;
            state_d   = StApply;
          end else begin
            sub_cnt_d = sub_cnt_q + 16'd1;
          end
        end
        StApply: begin
          if (sub_cnt_q == 16'(SETTLE - 1)) begin
            sub_cnt_d = 16'd0;
            state_d   = StCheck;
          end else begin
            sub_cnt_d = sub_cnt_q + 16'd1;
          end
        end
        StCheck: begin
          if (mismatch) begin
            detected_d  = 1'b1;
            det_index_d = pat_idx_q;
            state_d     = StDone;
          end else if (pat_idx_q == num_pat_q - 16'd1) begin
            state_d = StDone;
          end else begin
            pat_idx_d = pat_idx_q + 16'd1;
            state_d   = StFill;
          end
        end
        StDone: begin
          state_d = StIdle;
          if (fault_cnt_q != 16'hFFFF) fault_cnt_d = fault_cnt_q + 16'd1;
          if (detected_q && (det_cnt_q != 16'hFFFF)) det_cnt_d = det_cnt_q + 16'd1;
        end
        default: state_d = StIdle;
      endcase
    end

    if (clr_stats) begin
      fault_cnt_d = 16'd0;
      det_cnt_d   = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sub_cnt_q   <= 16'd0;
      pat_idx_q   <= 16'd0;
      num_pat_q   <= 16'd0;
      detected_q  <= 1'b0;
      det_index_q <= 16'd0;
      fault_cnt_q <= 16'd0;
      det_cnt_q   <= 16'd0;
      sr_q        <= '0;
    end else begin
      state_q     <= state_d;
      sub_cnt_q   <= sub_cnt_d;
      pat_idx_q   <= pat_idx_d;
      num_pat_q   <= num_pat_d;
      detected_q  <= detected_d;
      det_index_q <= det_index_d;
      fault_cnt_q <= fault_cnt_d;
      det_cnt_q   <= det_cnt_d;
      sr_q        <= sr_d;
    end
  end

  assign vec_out   = sr_q;
  assign vec_valid = ((state_q == StApply) || (state_q == StCheck)) && !abort_req;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone) && !abort_req;
  assign detected  = detected_q;
  assign det_index = det_index_q;
  assign fault_cnt = fault_cnt_q;
  assign det_cnt   = det_cnt_q;

endmodule
